// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate result checker: FSM state encoding and
// the default counter width.
package gate_chk_pkg;

    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } chk_state_t;

endpackage : gate_chk_pkg

// File: rtl/gate_ref_model.sv
// Golden response of the universal-gate stage: what a correct NAND/NOR pair
// must produce for a given a/b stimulus.
module gate_ref_model (
    input  logic a,
    input  logic b,
    output logic nand_exp,
    output logic nor_exp
);

    assign nand_exp = ~(a & b);
    assign nor_exp  = ~(a | b);

endmodule : gate_ref_model

// File: rtl/gate_result_checker.sv
// Checks a stream of a/b -> nand_out/nor_out samples against the golden
// gate model for a requested number of vectors, and reports counts,
// input-combination coverage, the first failing vector and a pass verdict.
module gate_result_checker
    import gate_chk_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             nand_out,
    input  logic             nor_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [3:0]       cov_map,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             first_err_vld
);

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    chk_state_t       state_r;
    logic [CNT_W-1:0] num_lat_r;
    logic [CNT_W-1:0] vec_count_r;
    logic [CNT_W-1:0] err_count_r;
    logic [3:0]       cov_map_r;
    logic [CNT_W-1:0] first_err_idx_r;
    logic             first_err_vld_r;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;

    logic             nand_exp_s;
    logic             nor_exp_s;
    logic             mismatch_s;
    logic             accept_s;
    logic [CNT_W-1:0] vec_inc_s;
    logic [CNT_W-1:0] err_nxt_s;
    logic [3:0]       cov_nxt_s;
    logic             last_s;

    gate_ref_model u_ref (
        .a        (a),
        .b        (b),
        .nand_exp (nand_exp_s),
        .nor_exp  (nor_exp_s)
    );

    // Per-sample evaluation: mismatch, next statistics and end-of-run detect.
    always_comb begin
        mismatch_s = (nand_out != nand_exp_s) || (nor_out != nor_exp_s);
        accept_s   = (state_r == ST_CHECK) && in_valid;
        vec_inc_s  = sat_inc(vec_count_r);
        if (mismatch_s) begin
            err_nxt_s = sat_inc(err_count_r);
        end else begin
            err_nxt_s = err_count_r;
        end
        cov_nxt_s           = cov_map_r;
        cov_nxt_s[{a, b}]   = 1'b1;
        last_s              = (vec_inc_s == num_lat_r);
    end

    // Run-control FSM with registered status outputs and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            num_lat_r       <= {CNT_W{1'b0}};
            vec_count_r     <= {CNT_W{1'b0}};
            err_count_r     <= {CNT_W{1'b0}};
            cov_map_r       <= 4'h0;
            first_err_idx_r <= {CNT_W{1'b0}};
            first_err_vld_r <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            pass_r          <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    // A start wins over a simultaneous in_valid here.
                    if (start) begin
                        num_lat_r       <= num_vectors;
                        vec_count_r     <= {CNT_W{1'b0}};
                        err_count_r     <= {CNT_W{1'b0}};
                        cov_map_r       <= 4'h0;
                        first_err_idx_r <= {CNT_W{1'b0}};
                        first_err_vld_r <= 1'b0;
                        pass_r          <= 1'b0;
                        if (num_vectors == {CNT_W{1'b0}}) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_CHECK;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_CHECK: begin
                    // start is deliberately ignored while a run is active.
                    if (accept_s) begin
                        vec_count_r <= vec_inc_s;
                        err_count_r <= err_nxt_s;
                        cov_map_r   <= cov_nxt_s;
                        if (mismatch_s && !first_err_vld_r) begin
                            first_err_idx_r <= vec_count_r;
                            first_err_vld_r <= 1'b1;
                        end else begin
                            first_err_vld_r <= first_err_vld_r;
                        end
                        if (last_s) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            pass_r  <= (err_nxt_s == {CNT_W{1'b0}}) && (cov_nxt_s == 4'hF);
                        end else begin
                            state_r <= ST_CHECK;
                        end
                    end else begin
                        state_r <= ST_CHECK;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    pass_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign vec_count     = vec_count_r;
    assign err_count     = err_count_r;
    assign cov_map       = cov_map_r;
    assign first_err_idx = first_err_idx_r;
    assign first_err_vld = first_err_vld_r;

endmodule : gate_result_checker

// File: tb/tb_gate_result_checker.sv
// Self-checking bench for gate_result_checker: directed scenarios followed
// by randomized traffic, all compared against a run-level reference model
// that keeps the list of accepted samples and derives every output from it.
module tb_gate_result_checker;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, in_valid, a, b, nand_out, nor_out;
    logic [W-1:0] num_vectors;
    logic         busy, done, pass, first_err_vld;
    logic [W-1:0] vec_count, err_count, first_err_idx;
    logic [3:0]   cov_map;

    int checks   = 0;
    int failures = 0;

    // Reference model: a run is "started" with a target; accepted samples
    // are kept as (ab, faulty) records.
    bit       m_started;
    int       m_target;
    bit [1:0] q_ab[$];
    bit       q_bad[$];

    always #5 clk = ~clk;

    gate_result_checker #(.CNT_W(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_vectors   (num_vectors),
        .in_valid      (in_valid),
        .a             (a),
        .b             (b),
        .nand_out      (nand_out),
        .nor_out       (nor_out),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .vec_count     (vec_count),
        .err_count     (err_count),
        .cov_map       (cov_map),
        .first_err_idx (first_err_idx),
        .first_err_vld (first_err_vld)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Compare every output against what the accepted-sample list implies.
    task automatic compare_model();
        int  e_err  = 0;
        int  e_fidx = 0;
        bit  e_fvld = 1'b0;
        int  e_vec;
        bit [3:0] e_cov = 4'h0;
        bit  e_busy, e_done, e_pass;
        e_vec = (q_ab.size() > 255) ? 255 : q_ab.size();
        for (int i = 0; i < q_ab.size(); i++) begin
            e_cov[q_ab[i]] = 1'b1;
            if (q_bad[i]) begin
                if (e_err < 255) e_err++;
                if (!e_fvld) begin
                    e_fvld = 1'b1;
                    e_fidx = i;
                end
            end
        end
        e_busy = m_started && (q_ab.size() < m_target);
        e_done = m_started && (q_ab.size() >= m_target);
        e_pass = e_done && (e_err == 0) && (e_cov == 4'hF);
        check_eq("busy",          32'(busy),          32'(e_busy));
        check_eq("done",          32'(done),          32'(e_done));
        check_eq("pass",          32'(pass),          32'(e_pass));
        check_eq("vec_count",     32'(vec_count),     32'(e_vec));
        check_eq("err_count",     32'(err_count),     32'(e_err));
        check_eq("cov_map",       32'(cov_map),       32'(e_cov));
        check_eq("first_err_idx", 32'(first_err_idx), 32'(e_fidx));
        check_eq("first_err_vld", 32'(first_err_vld), 32'(e_fvld));
    endtask

    // One clock: drive inputs (upstream gate plus optional faults), advance
    // the model, then sample DUT outputs just after the edge.
    task automatic step(input bit r, input bit s, input int n, input bit v,
                        input bit ia, input bit ib, input bit fnand, input bit fnor);
        bit running;
        rst         = r;
        start       = s;
        num_vectors = n[W-1:0];
        in_valid    = v;
        a           = ia;
        b           = ib;
        nand_out    = (~(ia & ib)) ^ fnand;
        nor_out     = (~(ia | ib)) ^ fnor;
        running = m_started && (q_ab.size() < m_target);
        if (r) begin
            m_started = 1'b0;
            m_target  = 0;
            q_ab.delete();
            q_bad.delete();
        end else if (!running) begin
            if (s) begin
                m_started = 1'b1;
                m_target  = n & 255;
                q_ab.delete();
                q_bad.delete();
            end
        end else if (v) begin
            q_ab.push_back({ia, ib});
            q_bad.push_back(fnand | fnor);
        end
        @(posedge clk);
        #1;
        compare_model();
        @(negedge clk);
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic vec(input bit [1:0] ab, input bit fnor);
        step(1'b0, 1'b0, 0, 1'b1, ab[1], ab[0], 1'b0, fnor);
    endtask

    task automatic go(input int n);
        step(1'b0, 1'b1, n, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; a = 1'b0; b = 1'b0;
        nand_out = 1'b1; nor_out = 1'b1; num_vectors = '0;
        m_started = 1'b0; m_target = 0;
        @(negedge clk);
        step(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_vec",  32'(vec_count), 32'd0);

        // Full correct run over all four combinations.
        go(4);
        vec(2'b00, 1'b0); vec(2'b01, 1'b0); vec(2'b10, 1'b0);
        check_eq("t1_not_done_yet", 32'(done), 32'd0);
        vec(2'b11, 1'b0);
        check_eq("t1_done", 32'(done), 32'd1);
        check_eq("t1_vec",  32'(vec_count), 32'd4);
        check_eq("t1_cov",  32'(cov_map), 32'hF);
        check_eq("t1_pass", 32'(pass), 32'd1);
        idle_step();
        check_eq("t1_done_level", 32'(done), 32'd1);

        // Incomplete coverage fails.
        go(3);
        vec(2'b00, 1'b0); vec(2'b01, 1'b0); vec(2'b10, 1'b0);
        check_eq("t2_cov",  32'(cov_map), 32'h7);
        check_eq("t2_pass", 32'(pass), 32'd0);
        check_eq("t2_err",  32'(err_count), 32'd0);

        // Faulty nor on the third vector.
        go(5);
        vec(2'b00, 1'b0); vec(2'b01, 1'b0); vec(2'b10, 1'b1);
        vec(2'b11, 1'b0); vec(2'b00, 1'b0);
        check_eq("t3_err",  32'(err_count), 32'd1);
        check_eq("t3_fidx", 32'(first_err_idx), 32'd2);
        check_eq("t3_fvld", 32'(first_err_vld), 32'd1);
        check_eq("t3_pass", 32'(pass), 32'd0);

        // Extra valids and a mid-run start.
        go(2);
        vec(2'b01, 1'b0);
        step(1'b0, 1'b1, 9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vec(2'b11, 1'b0); vec(2'b00, 1'b0);
        check_eq("t4_vec",  32'(vec_count), 32'd2);
        check_eq("t4_done", 32'(done), 32'd1);

        // start together with in_valid in DONE: only the start counts.
        step(1'b0, 1'b1, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("t4b_vec",  32'(vec_count), 32'd0);
        check_eq("t4b_busy", 32'(busy), 32'd1);

        // Reset mid-run, then a clean new run.
        go(6);
        vec(2'b00, 1'b0); vec(2'b01, 1'b1);
        step(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_err",  32'(err_count), 32'd0);
        check_eq("t5_fvld", 32'(first_err_vld), 32'd0);
        go(2);
        vec(2'b10, 1'b0); vec(2'b11, 1'b0);
        check_eq("t5_rerun_vec",  32'(vec_count), 32'd2);
        check_eq("t5_rerun_done", 32'(done), 32'd1);

        // Zero-length run, then a maximal run with overflowing valids.
        go(0);
        check_eq("t6_zero_done", 32'(done), 32'd1);
        check_eq("t6_zero_pass", 32'(pass), 32'd0);
        go(255);
        for (int i = 0; i < 300; i++) begin
            vec(2'($urandom_range(3, 0)), 1'b0);
        end
        check_eq("t6_sat_vec",  32'(vec_count), 32'd255);
        check_eq("t6_sat_done", 32'(done), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(63, 0) == 0),
                 ($urandom_range(7, 0) == 0),
                 ($urandom_range(3, 0) == 0) ? int'($urandom_range(255, 0)) : int'($urandom_range(12, 0)),
                 ($urandom_range(3, 0) != 0),
                 1'($urandom), 1'($urandom),
                 ($urandom_range(15, 0) == 0),
                 ($urandom_range(15, 0) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_gate_result_checker

// File: doc/gate_result_checker.md
GATE_RESULT_CHECKER -- requirements
Module: gate_result_checker

Interface
REQ-001 The block SHALL have the parameter CNT_W, default 8, meaning the width of the vector and error counters.
REQ-002 The block SHALL have the port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have the port start, input, 1 bit, which requests a new check run.
REQ-005 The block SHALL have the port num_vectors, input, CNT_W bits, the number of vectors to check; it is latched on an accepted start.
REQ-006 The block SHALL have the port in_valid, input, 1 bit, which marks the a/b/nand_out/nor_out sample as valid this cycle.
REQ-007 The block SHALL have the ports a and b, inputs, 1 bit each, the stimulus applied to the universal-gate stage.
REQ-008 The block SHALL have the ports nand_out and nor_out, inputs, 1 bit each, the responses of the universal-gate stage.
REQ-009 The block SHALL have the port busy, output, 1 bit, high while in CHECK.
REQ-010 The block SHALL have the port done, output, 1 bit, high while in DONE.
REQ-011 The block SHALL have the port pass, output, 1 bit, valid only while done is high.
REQ-012 The block SHALL have the ports vec_count and err_count, outputs, CNT_W bits each, the number of vectors checked and the number of mismatching vectors.
REQ-013 The block SHALL have the port cov_map, output, 4 bits; bit {a,b} is set once that input combination has been checked.
REQ-014 The block SHALL have the ports first_err_idx, output, CNT_W bits, and first_err_vld, output, 1 bit, giving the vec_count value at the first mismatch.

Function
REQ-015 The FSM SHALL have the states IDLE, CHECK and DONE.
REQ-016 In IDLE or DONE, start=1 SHALL clear all statistics, latch num_vectors and enter CHECK on the next cycle; if num_vectors=0, it SHALL enter DONE instead.
REQ-017 In CHECK, start SHALL be ignored.
REQ-018 A sample SHALL be accepted only when in CHECK with in_valid=1; in_valid SHALL be ignored in IDLE and DONE.
REQ-019 The expected values SHALL be nand_exp = ~(a&b) and nor_exp = ~(a|b).
REQ-020 A mismatch SHALL be nand_out != nand_exp or nor_out != nor_exp.
REQ-021 On an accepted sample, vec_count, err_count, cov_map and first_err_* SHALL update at that same clock edge, giving the outputs one-cycle latency.
REQ-022 first_err_idx SHALL capture the pre-increment vec_count of the first mismatch only; first_err_vld SHALL be sticky until the next start or rst.
REQ-023 The sample that makes vec_count equal the latched num_vectors SHALL move the FSM to DONE at that edge; later in_valid pulses SHALL change nothing.
REQ-024 Counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-025 pass SHALL be 1 iff err_count=0 and cov_map=4'hF.
REQ-026 DONE SHALL hold until start or rst; done SHALL be a level signal, not a pulse.
REQ-027 When start=1 and in_valid=1 in the same cycle in IDLE or DONE, only the start SHALL take effect.

Reset
REQ-028 rst=1 SHALL force the FSM to IDLE on the next edge, including mid-run.
REQ-029 After rst, busy, done, pass and first_err_vld SHALL be 0, and vec_count, err_count, cov_map and first_err_idx SHALL be 0.
REQ-030 rst SHALL take priority over start and in_valid.

Structure
REQ-031 The state encoding (IDLE=2'd0, CHECK=2'd1, DONE=2'd2) and the CNT_W default SHALL live in the shared package gate_chk_pkg.
REQ-032 The expected-value computation SHALL be one combinational sub-module, gate_ref_model (inputs a and b; outputs nand_exp and nor_exp).
REQ-033 The universal-gate stage SHALL be instantiated upstream by the bench only, not inside this block.

Verification
REQ-034 rst; start with num_vectors=4; feed ab=00,01,10,11 from a correct gate -> DONE after the 4th edge, vec_count=4, err_count=0, cov_map=F, pass=1.
REQ-035 num_vectors=3, ab=00,01,10 correct -> cov_map=7, pass=0, err_count=0.
REQ-036 num_vectors=5 with nor_out forced wrong on the 3rd vector -> err_count=1, first_err_idx=2, first_err_vld=1, pass=0.
REQ-037 num_vectors=2 with 4 in_valid pulses, and a start pulse mid-run -> start ignored, vec_count=2, stays DONE.
REQ-038 rst asserted after 2 vectors of a 6-vector run -> next cycle IDLE with all outputs 0; a new start then runs cleanly.
REQ-039 num_vectors=0 -> DONE one cycle after start, pass=0; num_vectors=255 with 300 valid cycles -> vec_count=255 with no wrap.
